// File: rtl/clocked_dlatch_delay.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// clocked_dlatch_delay
//   Gate-level, delay-annotated level-sensitive D latch built from NAND/NOT
//   primitives. Each gate carries its own propagation delay so propagation,
//   glitch and hold behaviour show up in simulation waveforms.
//
// Ports
//   clk   : latch gate, high = transparent, low = hold
//   rst   : synchronous active-high reset, effective only while clk = 1
//   D     : data input
//   Q     : latched data
//   Q_bar : complement of Q in steady state (both may be 1 briefly while
//           the latch is switching)
//
// Parameters
//   NAND_DELAY : propagation delay (ns) of every NAND gate
//   NOT_DELAY  : propagation delay (ns) of the data inverter
// ---------------------------------------------------------------------------
module clocked_dlatch_delay #(
    parameter int unsigned NAND_DELAY = 2,
    parameter int unsigned NOT_DELAY  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic D,
    output logic Q,
    output logic Q_bar
);

    logic d_int;
    logic dn;
    logic s_n;
    logic r_n;

    // Reset folds into the data term with zero delay. Because the steering
    // NANDs only pass data while clk = 1, reset is naturally confined to the
    // transparent phase and adds no latency to the data path.
    assign d_int = D & ~rst;

    // Data inverter feeding the reset-side steering gate.
    assign #(NOT_DELAY) dn = ~d_int;

    // Steering gates: both idle high while the gate is closed.
    assign #(NAND_DELAY) s_n = ~(d_int & clk);
    assign #(NAND_DELAY) r_n = ~(dn & clk);

    // Cross-coupled storage pair. Power-up state is left unresolved until the
    // first transparent phase drives one side low.
    assign #(NAND_DELAY) Q     = ~(s_n & Q_bar);
    assign #(NAND_DELAY) Q_bar = ~(r_n & Q);

endmodule

// File: tb/tb_clocked_dlatch_delay.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_clocked_dlatch_delay
//   Directed, table-driven bench for the delay-annotated D latch. Each table
//   record applies {clk, rst, D}, waits a number of ns, then compares Q and
//   Q_bar against hand-computed values. Sample points sit between gate
//   events so each check lands on a stable value.
// ---------------------------------------------------------------------------
module tb_clocked_dlatch_delay;

    logic clk;
    logic rst;
    logic d;
    logic q;
    logic q_bar;

    int unsigned checks;
    int unsigned errors;

    typedef struct {
        logic        clk;
        logic        rst;
        logic        d;
        int unsigned wait_ns;
        logic        exp_q;
        logic        exp_qb;
    } vec_t;

    vec_t vecs[$];

    clocked_dlatch_delay #(
        .NAND_DELAY (2),
        .NOT_DELAY  (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .D     (d),
        .Q     (q),
        .Q_bar (q_bar)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t ns", name, act, exp, $time);
        end
    endtask

    task automatic wait_ns(input int unsigned n);
        repeat (n) #1;
    endtask

    function automatic void add(input logic c, input logic r, input logic dv,
                                input int unsigned w, input logic eq, input logic eqb);
        vec_t v;
        v.clk = c; v.rst = r; v.d = dv; v.wait_ns = w; v.exp_q = eq; v.exp_qb = eqb;
        vecs.push_back(v);
    endfunction

    initial begin
        checks = 0;
        errors = 0;

        // Transparent tracking, starting from Q=0 with clk high and D=0.
        add(1,0,1, 3, 0,1);   // D rise: Q not yet up at +3
        add(1,0,1, 2, 1,1);   // +5: Q up, Q_bar still high (transient)
        add(1,0,1, 2, 1,0);   // +7: Q_bar down
        add(1,0,1,53, 1,0);
        add(1,0,0, 4, 1,0);   // D fall: nothing yet at +4
        add(1,0,0, 2, 1,1);   // +6: Q_bar up at +5, Q still high
        add(1,0,0, 2, 0,1);   // +8: Q down at +7
        add(1,0,0,52, 0,1);
        // Load a 1 then close the gate and toggle D.
        add(1,0,1,10, 1,0);
        add(0,0,1,10, 1,0);
        add(0,0,0,30, 1,0);
        add(0,0,1,30, 1,0);
        add(0,0,0,30, 1,0);
        // Reset pulse while the gate is closed is ignored.
        add(0,1,0,25, 1,0);
        add(0,1,1,25, 1,0);
        add(0,0,1,10, 1,0);
        // Capture on open with D=1 after holding 0.
        add(1,0,0,10, 0,1);
        add(0,0,0,10, 0,1);
        add(0,0,1,10, 0,1);
        add(1,0,1, 3, 0,1);   // clk rise: Q rises at +4
        add(1,0,1, 2, 1,1);   // +5
        add(1,0,1, 2, 1,0);   // +7: Q_bar fell at +6
        add(1,0,1,10, 1,0);
        // Capture on open with D=0 after holding 1.
        add(0,0,1,10, 1,0);
        add(0,0,0,10, 1,0);
        add(1,0,0, 3, 1,0);   // clk rise: Q_bar rises at +4
        add(1,0,0, 2, 1,1);   // +5
        add(1,0,0, 2, 0,1);   // +7: Q fell at +6
        add(1,0,0,10, 0,1);
        // Synchronous reset with the gate open.
        add(1,0,1,10, 1,0);
        add(1,1,1, 6, 1,1);   // Q_bar up at +5, Q still high
        add(1,1,1, 2, 0,1);   // Q down at +7
        add(1,1,1,10, 0,1);
        // Reset released with the gate open: normal D latency.
        add(1,0,1, 3, 0,1);
        add(1,0,1, 2, 1,1);
        add(1,0,1,10, 1,0);
        // Reset asserted together with the gate opening.
        add(0,0,1,10, 1,0);
        add(1,1,1, 8, 0,1);
        add(1,1,1,10, 0,1);

        // Power-up: gate closed with D=0, first opening at 200 ns resolves it.
        clk = 1'b0;
        rst = 1'b0;
        d   = 1'b0;
        wait_ns(200);
        clk = 1'b1;
        wait_ns(8);
        check("powerup Q", q, 1'b0);
        check("powerup Q_bar", q_bar, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            clk = vecs[i].clk;
            rst = vecs[i].rst;
            d   = vecs[i].d;
            wait_ns(vecs[i].wait_ns);
            check($sformatf("vec%0d Q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d Q_bar", i), q_bar, vecs[i].exp_qb);
        end

        // Final sequence: open with D=1, then close and drop D in the same step.
        rst = 1'b0;
        d   = 1'b1;
        clk = 1'b1;
        wait_ns(60);
        check("final open Q", q, 1'b1);
        check("final open Q_bar", q_bar, 1'b0);
        clk = 1'b0;
        d   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_ns(k == 0 ? 3 : 20);
            check($sformatf("final hold%0d Q", k), q, 1'b1);
            check($sformatf("final hold%0d Q_bar", k), q_bar, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
